// File: rtl/vend_pkg.sv
// vend_pkg: shared types for the vending front-end controller.
//   coin_e        coin code as seen on the entry ports and stored in the FIFOs
//   ctrl_state_e  controller FSM states
//   CHANGE_W      width of the core's change output (units of 5 cents)
package vend_pkg;

    typedef enum logic [1:0] {
        COIN_BAD = 2'd0,
        NICKEL   = 2'd1,
        DIME     = 2'd2,
        QUARTER  = 2'd3
    } coin_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_VEND,
        ST_PAYOUT
    } ctrl_state_e;

    localparam int CHANGE_W = 3;

endpackage

// File: rtl/vend_coin_fifo.sv
// vend_coin_fifo: small per-port coin queue.
//   clk, rst    clock, asynchronous active-high reset
//   push        offer a coin (transfer when push & ready)
//   push_data   coin code; COIN_BAD is accepted on the handshake but dropped
//   pop         remove head entry (ignored when empty)
//   head        head entry
//   empty       queue holds no coins
//   ready       registered "not full"; low while in reset
module vend_coin_fifo
    import vend_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  push,
    input  coin_e push_data,
    input  logic  pop,
    output coin_e head,
    output logic  empty,
    output logic  ready
);

    localparam int AW = $clog2(DEPTH);

    coin_e          mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic [AW:0]    count_nxt;
    logic           do_push;
    logic           do_pop;

    // ready reflects the current count, so a pop in the same cycle never
    // opens room for a push on a full queue.
    assign do_push   = push && ready && (push_data != COIN_BAD);
    assign do_pop    = pop && !empty;
    assign count_nxt = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    assign empty     = (count == '0);
    assign head      = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ready  <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            ready <= (count_nxt != (AW+1)'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/vend_ctrl.sv
// vend_ctrl: front-end controller for the vending FSM core.
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_coin_valid/type       two coin entry ports (0 front slot, 1 cashless)
//   o_coin_ready            per-port FIFO not full
//   o_core_nickel/dime/quarter  one-cycle coin pulse to the core
//   i_core_soda/change      core result, valid one cycle after the pulse
//   o_vend_req/i_vend_ack   soda motor handshake
//   o_nickel_req/i_nickel_ack  change hopper handshake, one nickel each
//   o_busy                  FSM away from IDLE
//   o_fault                 sticky ack timeout flag
//   o_sold_cnt              sodas dispensed, counted on vend ack
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int TMO_W      = 8,
    parameter int CNT_W      = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [1:0]          i_coin_valid,
    input  logic [1:0][1:0]     i_coin_type,
    output logic [1:0]          o_coin_ready,
    output logic                o_core_nickel,
    output logic                o_core_dime,
    output logic                o_core_quarter,
    input  logic                i_core_soda,
    input  logic [CHANGE_W-1:0] i_core_change,
    output logic                o_vend_req,
    input  logic                i_vend_ack,
    output logic                o_nickel_req,
    input  logic                i_nickel_ack,
    output logic                o_busy,
    output logic                o_fault,
    output logic [CNT_W-1:0]    o_sold_cnt
);

    coin_e        head [2];
    logic [1:0]   fifo_empty;
    logic [1:0]   pop;

    for (genvar p = 0; p < 2; p++) begin : g_fifo
        vend_coin_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk       (i_clk),
            .rst       (i_rst),
            .push      (i_coin_valid[p]),
            .push_data (coin_e'(i_coin_type[p])),
            .pop       (pop[p]),
            .head      (head[p]),
            .empty     (fifo_empty[p]),
            .ready     (o_coin_ready[p])
        );
    end

    ctrl_state_e          state, state_d;
    coin_e                coin_q, coin_d;
    logic [CHANGE_W-1:0]  pay_cnt, pay_d;
    logic [TMO_W-1:0]     tmo, tmo_d;
    logic                 gap, gap_d;     // one idle cycle between nickel reqs
    logic                 prio, prio_d;   // port that wins a tie
    logic                 fault_d;
    logic [CNT_W-1:0]     sold_d;
    logic                 win;

    assign win = fifo_empty[prio] ? ~prio : prio;

    always_comb begin
        state_d = state;
        coin_d  = coin_q;
        pay_d   = pay_cnt;
        tmo_d   = tmo;
        gap_d   = gap;
        prio_d  = prio;
        fault_d = o_fault;
        sold_d  = o_sold_cnt;
        pop     = '0;
        case (state)
            ST_IDLE: begin
                if (!(&fifo_empty)) begin
                    pop[win] = 1'b1;
                    coin_d   = head[win];
                    prio_d   = ~win;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (i_core_soda) begin
                    pay_d   = i_core_change;
                    tmo_d   = '0;
                    state_d = ST_VEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_VEND: begin
                if (i_vend_ack) begin
                    sold_d  = o_sold_cnt + 1'b1;
                    tmo_d   = '0;
                    gap_d   = 1'b0;
                    state_d = (pay_cnt != '0) ? ST_PAYOUT : ST_IDLE;
                end else if (&tmo) begin
                    fault_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo + 1'b1;
                end
            end
            ST_PAYOUT: begin
                if (gap) begin
                    gap_d = 1'b0;
                    tmo_d = '0;
                end else if (i_nickel_ack) begin
                    pay_d = pay_cnt - 1'b1;
                    if (pay_cnt == CHANGE_W'(1)) state_d = ST_IDLE;
                    else                         gap_d   = 1'b1;
                end else if (&tmo) begin
                    // hopper stuck: give up on the remaining change
                    fault_d = 1'b1;
                    pay_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next-state decode so they line up
    // with the state they belong to.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state          <= ST_IDLE;
            coin_q         <= COIN_BAD;
            pay_cnt        <= '0;
            tmo            <= '0;
            gap            <= 1'b0;
            prio           <= 1'b0;
            o_fault        <= 1'b0;
            o_sold_cnt     <= '0;
            o_core_nickel  <= 1'b0;
            o_core_dime    <= 1'b0;
            o_core_quarter <= 1'b0;
            o_vend_req     <= 1'b0;
            o_nickel_req   <= 1'b0;
            o_busy         <= 1'b0;
        end else begin
            state          <= state_d;
            coin_q         <= coin_d;
            pay_cnt        <= pay_d;
            tmo            <= tmo_d;
            gap            <= gap_d;
            prio           <= prio_d;
            o_fault        <= fault_d;
            o_sold_cnt     <= sold_d;
            o_core_nickel  <= (state_d == ST_ISSUE) && (coin_d == NICKEL);
            o_core_dime    <= (state_d == ST_ISSUE) && (coin_d == DIME);
            o_core_quarter <= (state_d == ST_ISSUE) && (coin_d == QUARTER);
            o_vend_req     <= (state_d == ST_VEND);
            o_nickel_req   <= (state_d == ST_PAYOUT) && !gap_d;
            o_busy         <= (state_d != ST_IDLE);
        end
    end

endmodule
